// File: rtl/key_bank_pkg.sv
// key_bank_pkg: shared types and elaboration helpers for the key bank.
// The FSM state type lives here so the top level and any future
// sub-blocks agree on one encoding.
package key_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT,
    ZERO
  } state_t;

  // Number of load beats that make up one key.
  function automatic int words(input int key_w, input int data_w);
    return key_w / data_w;
  endfunction

  // A key must split into a whole number of beats.
  function automatic bit width_ok(input int key_w, input int data_w);
    return (data_w > 0) && ((key_w % data_w) == 0);
  endfunction

endpackage

// File: rtl/key_bank_if.sv
// key_bank_if: load stream, lock, zeroize and read-port signals of the
// key bank. The master side drives requests, the slave side is the store.
interface key_bank_if #(
  parameter int KEY_W   = 128,
  parameter int DATA_W  = 32,
  parameter int N_SLOTS = 4
);
  localparam int SLOT_AW = $clog2(N_SLOTS);

  logic               wr_valid;
  logic               wr_ready;
  logic [SLOT_AW-1:0] wr_slot;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_done;
  logic               wr_err;
  logic               lock_req;
  logic [SLOT_AW-1:0] lock_slot;
  logic               zeroize;
  logic               zeroize_done;
  logic               busy;
  logic               rd_req;
  logic [SLOT_AW-1:0] rd_slot;
  logic               rd_valid;
  logic [KEY_W-1:0]   rd_data;
  logic               rd_err;

  modport master (
    output wr_valid, wr_slot, wr_data, lock_req, lock_slot, zeroize, rd_req, rd_slot,
    input  wr_ready, wr_done, wr_err, zeroize_done, busy, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_valid, wr_slot, wr_data, lock_req, lock_slot, zeroize, rd_req, rd_slot,
    output wr_ready, wr_done, wr_err, zeroize_done, busy, rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/key_bank_loader.sv
// key_bank_loader: assembles a key from DATA_W-bit beats, least
// significant word first, into a shadow register. last_beat flags the
// accepted beat that completes the key so the FSM can move to commit.
module key_bank_loader
  import key_bank_pkg::*;
#(
  parameter int KEY_W  = 128,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic              clear,
  input  logic [DATA_W-1:0] beat,
  output logic [KEY_W-1:0]  shadow,
  output logic              last_beat
);

  localparam int WORDS = words(KEY_W, DATA_W);
  localparam int CNT_W = $clog2(WORDS) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] shadow_q;

  assign shadow    = shadow_q;
  assign last_beat = accept && (cnt_q == CNT_W'(WORDS - 1));

  // Drop each accepted beat into the word selected by the beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      for (int w = 0; w < WORDS; w++) begin
        if (cnt_q == CNT_W'(w)) begin
          shadow_q[w*DATA_W +: DATA_W] <= beat;
        end
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/key_bank_storage.sv
// key_bank_storage: multi-slot key store feeding the bitstream decrypt
// path. Keys are streamed in beat by beat, committed atomically, can be
// write-locked per slot and are wiped by a one-slot-per-cycle zeroize sweep.
// Optional feature macro: KEY_BANK_PARITY_EN adds one even-parity bit per
// slot that is checked on every read.
module key_bank_storage
  import key_bank_pkg::*;
#(
  parameter int KEY_W   = 128,
  parameter int DATA_W  = 32,
  parameter int N_SLOTS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  key_bank_if.slave    bus
);

  localparam int SLOT_AW = $clog2(N_SLOTS);
  localparam int WORDS   = words(KEY_W, DATA_W);
  localparam logic [SLOT_AW-1:0] LAST_SLOT = SLOT_AW'(N_SLOTS - 1);

  generate
    if (!width_ok(KEY_W, DATA_W) || (N_SLOTS < 2)) begin : g_param_check
      $error("key_bank_storage: KEY_W must be a multiple of DATA_W and N_SLOTS >= 2");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [SLOT_AW-1:0] slot_q;
  logic [SLOT_AW-1:0] zidx_q;
  logic [KEY_W-1:0]   slots [N_SLOTS];
  logic [N_SLOTS-1:0] valid_q;
  logic [N_SLOTS-1:0] lock_q;

  logic               accept;
  logic               loader_clear;
  logic               last_beat;
  logic [KEY_W-1:0]   shadow;
  logic               commit_ok;
  logic               commit_refused;
  logic               load_abort;
  logic               parity_bad;
  logic               rd_fault;

  logic               rd_valid_q;
  logic               rd_err_q;
  logic [KEY_W-1:0]   rd_data_q;

  // A zeroize request outranks a beat presented in the same cycle.
  assign accept       = bus.wr_valid && bus.wr_ready && !bus.zeroize;
  assign loader_clear = (state_q == COMMIT) || bus.zeroize;

  key_bank_loader #(
    .KEY_W  (KEY_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .clear     (loader_clear),
    .beat      (bus.wr_data),
    .shadow    (shadow),
    .last_beat (last_beat)
  );

  // Next-state and commit decisions; zeroize wins over everything else.
  always_comb begin
    state_d        = state_q;
    commit_ok      = 1'b0;
    commit_refused = 1'b0;
    load_abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.zeroize) begin
          state_d = ZERO;
        end else if (accept) begin
          state_d = (WORDS == 1) ? COMMIT : LOAD;
        end
      end
      LOAD: begin
        if (bus.zeroize) begin
          state_d    = ZERO;
          load_abort = 1'b1;
        end else if (last_beat) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (bus.zeroize) begin
          state_d    = ZERO;
          load_abort = 1'b1;
        end else begin
          state_d = IDLE;
          if (lock_q[slot_q]) begin
            commit_refused = 1'b1;
          end else begin
            commit_ok = 1'b1;
          end
        end
      end
      ZERO: begin
        if (zidx_q == LAST_SLOT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_ready     = rst_n && ((state_q == IDLE) || (state_q == LOAD));
  assign bus.busy         = rst_n && ((state_q == COMMIT) || (state_q == ZERO));
  assign bus.wr_done      = rst_n && commit_ok;
  assign bus.wr_err       = rst_n && (commit_refused || load_abort);
  assign bus.zeroize_done = rst_n && (state_q == ZERO) && (zidx_q == LAST_SLOT);

  // State register, target slot captured on the first beat, sweep index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      zidx_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && accept) begin
        slot_q <= bus.wr_slot;
      end
      if (state_q == ZERO) begin
        zidx_q <= zidx_q + 1'b1;
      end else begin
        zidx_q <= '0;
      end
    end
  end

  // Slot contents, valid and lock bits: sweep clears, commit writes, lock sets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        slots[i] <= '0;
      end
      valid_q <= '0;
      lock_q  <= '0;
    end else if (state_q == ZERO) begin
      slots[zidx_q]   <= '0;
      valid_q[zidx_q] <= 1'b0;
      lock_q[zidx_q]  <= 1'b0;
    end else begin
      if (commit_ok) begin
        slots[slot_q]   <= shadow;
        valid_q[slot_q] <= 1'b1;
      end
      if (bus.lock_req && !bus.zeroize) begin
        lock_q[bus.lock_slot] <= 1'b1;
      end
    end
  end

`ifdef KEY_BANK_PARITY_EN
  logic [N_SLOTS-1:0] parity_q;

  // Even parity of each committed key, wiped alongside its slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= '0;
    end else if (state_q == ZERO) begin
      parity_q[zidx_q] <= 1'b0;
    end else if (commit_ok) begin
      parity_q[slot_q] <= ^shadow;
    end
  end

  assign parity_bad = (^slots[bus.rd_slot]) != parity_q[bus.rd_slot];
`else
  assign parity_bad = 1'b0;
`endif

  assign rd_fault = !valid_q[bus.rd_slot] || (state_q == ZERO) || parity_bad;

  // Registered read port; sees slot contents from before the sampling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_req;
      rd_err_q   <= bus.rd_req && rd_fault;
      rd_data_q  <= (bus.rd_req && !rd_fault) ? slots[bus.rd_slot] : '0;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_key_bank_storage.sv
// tb_key_bank_storage: directed corner-case sequences, a small vector
// table and a randomized phase checked against an array-based model of
// the key bank (key, valid and lock per slot).
// Define KEY_BANK_PARITY_EN to also exercise the parity check.
module tb_key_bank_storage;

  localparam int KEY_W   = 128;
  localparam int DATA_W  = 32;
  localparam int N_SLOTS = 4;
  localparam int WORDS   = KEY_W / DATA_W;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  key_bank_if #(.KEY_W(KEY_W), .DATA_W(DATA_W), .N_SLOTS(N_SLOTS)) bus ();

  key_bank_storage #(.KEY_W(KEY_W), .DATA_W(DATA_W), .N_SLOTS(N_SLOTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vec_count   = 0;
  int miscompares = 0;

  logic [KEY_W-1:0] model_key   [N_SLOTS];
  bit               model_valid [N_SLOTS];
  bit               model_lock  [N_SLOTS];

  typedef struct {
    logic [1:0]       slot;
    logic [KEY_W-1:0] key;
    bit               lock_before;
    bit               exp_done;
    bit               exp_rd_err;
    logic [KEY_W-1:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [KEY_W-1:0] actual,
                             input logic [KEY_W-1:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.wr_valid  = 1'b0;
    bus.wr_slot   = '0;
    bus.wr_data   = '0;
    bus.lock_req  = 1'b0;
    bus.lock_slot = '0;
    bus.zeroize   = 1'b0;
    bus.rd_req    = 1'b0;
    bus.rd_slot   = '0;
  endtask

  task automatic modelClear();
    for (int i = 0; i < N_SLOTS; i++) begin
      model_key[i]   = '0;
      model_valid[i] = 1'b0;
      model_lock[i]  = 1'b0;
    end
  endtask

  // Stream a full key; later beats carry a different slot number, which
  // must be ignored. Returns wr_done/wr_err as seen in the commit cycle.
  task automatic applyStimulus(input logic [1:0] slot, input logic [KEY_W-1:0] key,
                               input int max_gap, output logic done, output logic err);
    for (int w = 0; w < WORDS; w++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) step();
      end
      bus.wr_valid = 1'b1;
      bus.wr_slot  = (w == 0) ? slot : ~slot;
      bus.wr_data  = key[w*DATA_W +: DATA_W];
      #1;
      checkOutput("wr_ready_during_load", bus.wr_ready, 1);
      step();
      bus.wr_valid = 1'b0;
    end
    #1;
    done = bus.wr_done;
    err  = bus.wr_err;
    checkOutput("busy_in_commit", bus.busy, 1);
    checkOutput("wr_ready_in_commit", bus.wr_ready, 0);
    step();
    checkOutput("wr_done_after_commit", bus.wr_done, 0);
  endtask

  task automatic partialLoad(input logic [1:0] slot, input int nbeats);
    for (int w = 0; w < nbeats; w++) begin
      bus.wr_valid = 1'b1;
      bus.wr_slot  = slot;
      bus.wr_data  = $urandom;
      step();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic readSlot(input logic [1:0] slot, output logic [KEY_W-1:0] data,
                          output logic err, output logic valid);
    bus.rd_req  = 1'b1;
    bus.rd_slot = slot;
    step();
    bus.rd_req = 1'b0;
    valid = bus.rd_valid;
    err   = bus.rd_err;
    data  = bus.rd_data;
  endtask

  task automatic checkRead(input string name, input logic [1:0] slot);
    logic [KEY_W-1:0] d;
    logic e, v;
    readSlot(slot, d, e, v);
    checkOutput({name, "_valid"}, v, 1);
    checkOutput({name, "_err"}, e, !model_valid[slot]);
    checkOutput({name, "_data"}, d, model_valid[slot] ? model_key[slot] : '0);
  endtask

  task automatic lockSlot(input logic [1:0] slot);
    bus.lock_req  = 1'b1;
    bus.lock_slot = slot;
    step();
    bus.lock_req = 1'b0;
    model_lock[slot] = 1'b1;
  endtask

  // Zeroize from the current state and follow the sweep to its end. A read
  // issued mid-sweep must be refused; an optional repeat request must not
  // restart the sweep.
  task automatic zeroizeAndCheck(input bit expect_err, input bit hold);
    int n;
    int done_at;
    bus.zeroize = 1'b1;
    #1;
    checkOutput("wr_err_on_zeroize_entry", bus.wr_err, expect_err);
    step();
    n = 0;
    done_at = -1;
    while (!bus.wr_ready && n < 20) begin
      bus.zeroize = hold && (n == 0);
      bus.rd_req  = (n == 1);
      bus.rd_slot = 2'd2;
      #1;
      if (n == 2) begin
        checkOutput("rd_err_during_zero", bus.rd_err, 1);
        checkOutput("rd_data_during_zero", bus.rd_data, 0);
      end
      checkOutput("busy_during_zero", bus.busy, 1);
      if (bus.zeroize_done) done_at = n;
      n++;
      step();
    end
    bus.zeroize = 1'b0;
    bus.rd_req  = 1'b0;
    checkOutput("zero_ready_low_cycles", n, N_SLOTS);
    checkOutput("zeroize_done_cycle", done_at, N_SLOTS - 1);
    checkOutput("busy_after_zero", bus.busy, 0);
    modelClear();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic d, e, v;
    logic [KEY_W-1:0] rdata;
    logic [KEY_W-1:0] k0, k1, k2, k3;

    idleInputs();
    modelClear();
    rst_n = 1'b0;
    repeat (2) step();
    checkOutput("reset_wr_ready", bus.wr_ready, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_rd_valid", bus.rd_valid, 0);
    rst_n = 1'b1;
    step();
    checkOutput("post_reset_wr_ready", bus.wr_ready, 1);
    checkOutput("post_reset_busy", bus.busy, 0);

    // Basic load and readback.
    applyStimulus(2'd2, 128'h0000_3E0C, 0, d, e);
    checkOutput("t1_wr_done", d, 1);
    checkOutput("t1_wr_err", e, 0);
    model_key[2] = 128'd15884;
    model_valid[2] = 1'b1;
    readSlot(2'd2, rdata, e, v);
    checkOutput("t1_rd_data", rdata, 128'd15884);
    checkOutput("t1_rd_err", e, 0);

    // Never-written slot.
    readSlot(2'd1, rdata, e, v);
    checkOutput("t2_rd_valid", v, 1);
    checkOutput("t2_rd_err", e, 1);
    checkOutput("t2_rd_data", rdata, 0);

    // Locked slot refuses a reload.
    lockSlot(2'd2);
    applyStimulus(2'd2, {KEY_W{1'b1}}, 0, d, e);
    checkOutput("t3_wr_done", d, 0);
    checkOutput("t3_wr_err", e, 1);
    checkRead("t3_read", 2'd2);

    // Zeroize aborting a load after two beats.
    partialLoad(2'd0, 2);
    zeroizeAndCheck(1'b1, 1'b0);
    for (int s = 0; s < N_SLOTS; s++) checkRead("t4_read_cleared", 2'(s));
    applyStimulus(2'd2, 128'h1234, 0, d, e);
    checkOutput("t4_unlocked_wr_done", d, 1);
    model_key[2] = 128'h1234;
    model_valid[2] = 1'b1;

    // Same-cycle read and commit of slot 3, plus a same-cycle lock.
    applyStimulus(2'd3, {4{32'hAAAA_AAAA}}, 0, d, e);
    checkOutput("t5_first_wr_done", d, 1);
    for (int w = 0; w < WORDS; w++) begin
      bus.wr_valid = 1'b1;
      bus.wr_slot  = 2'd3;
      bus.wr_data  = 32'h5555_5555;
      step();
    end
    bus.wr_valid  = 1'b0;
    bus.rd_req    = 1'b1;
    bus.rd_slot   = 2'd3;
    bus.lock_req  = 1'b1;
    bus.lock_slot = 2'd3;
    #1;
    checkOutput("t5_commit_with_lock_done", bus.wr_done, 1);
    step();
    bus.rd_req   = 1'b0;
    bus.lock_req = 1'b0;
    checkOutput("t5_old_key", bus.rd_data, {4{32'hAAAA_AAAA}});
    checkOutput("t5_old_key_err", bus.rd_err, 0);
    model_key[3] = {4{32'h5555_5555}};
    model_valid[3] = 1'b1;
    model_lock[3] = 1'b1;
    checkRead("t5_new_key", 2'd3);
    applyStimulus(2'd3, '0, 0, d, e);
    checkOutput("t5_locked_after_commit", e, 1);
    checkRead("t5_still_new_key", 2'd3);

`ifdef KEY_BANK_PARITY_EN
    // Corrupt one stored bit behind the parity bit's back.
    applyStimulus(2'd1, 128'h0F0F_0000_0000_0001, 0, d, e);
    checkOutput("t6_parity_load_done", d, 1);
    dut.slots[1][7] = ~dut.slots[1][7];
    readSlot(2'd1, rdata, e, v);
    checkOutput("t6_parity_rd_err", e, 1);
    checkOutput("t6_parity_rd_data", rdata, 0);
`endif

    // Reset in the middle of a load.
    bus.rd_req  = 1'b1;
    bus.rd_slot = 2'd3;
    partialLoad(2'd1, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_wr_ready", bus.wr_ready, 0);
    checkOutput("rst_mid_busy", bus.busy, 0);
    checkOutput("rst_mid_wr_done", bus.wr_done, 0);
    checkOutput("rst_mid_wr_err", bus.wr_err, 0);
    step();
    bus.rd_req = 1'b0;
    checkOutput("rst_mid_rd_valid", bus.rd_valid, 0);
    checkOutput("rst_mid_rd_data", bus.rd_data, 0);
    checkOutput("rst_mid_zeroize_done", bus.zeroize_done, 0);
    rst_n = 1'b1;
    step();
    checkOutput("rst_release_wr_ready", bus.wr_ready, 1);
    modelClear();
    checkRead("rst_slot3_cleared", 2'd3);

    // Vector table on an empty bank.
    k0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    k1 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;
    k2 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    k3 = {KEY_W{1'b1}};
    vecs[0] = '{2'd0, k0, 1'b0, 1'b1, 1'b0, k0};
    vecs[1] = '{2'd1, k1, 1'b1, 1'b0, 1'b1, '0};
    vecs[2] = '{2'd0, k2, 1'b0, 1'b1, 1'b0, k2};
    vecs[3] = '{2'd0, k3, 1'b1, 1'b0, 1'b0, k2};
    vecs[4] = '{2'd3, '0, 1'b0, 1'b1, 1'b0, '0};
    vecs[5] = '{2'd2, k1, 1'b0, 1'b1, 1'b0, k1};
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].lock_before) lockSlot(vecs[i].slot);
      applyStimulus(vecs[i].slot, vecs[i].key, 1, d, e);
      checkOutput("tbl_wr_done", d, vecs[i].exp_done);
      checkOutput("tbl_wr_err", e, !vecs[i].exp_done);
      readSlot(vecs[i].slot, rdata, e, v);
      checkOutput("tbl_rd_err", e, vecs[i].exp_rd_err);
      checkOutput("tbl_rd_data", rdata, vecs[i].exp_rd);
      if (vecs[i].exp_done) begin
        model_key[vecs[i].slot]   = vecs[i].key;
        model_valid[vecs[i].slot] = 1'b1;
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      int op;
      logic [1:0] s;
      logic [KEY_W-1:0] k;
      op = $urandom_range(0, 9);
      s  = 2'($urandom_range(0, N_SLOTS - 1));
      k  = {$urandom, $urandom, $urandom, $urandom};
      if (op <= 3) begin
        applyStimulus(s, k, 2, d, e);
        checkOutput("rand_wr_done", d, !model_lock[s]);
        checkOutput("rand_wr_err", e, model_lock[s]);
        if (!model_lock[s]) begin
          model_key[s]   = k;
          model_valid[s] = 1'b1;
        end
      end else if (op <= 6) begin
        checkRead("rand_read", s);
      end else if (op == 7) begin
        lockSlot(s);
      end else if (op == 8) begin
        zeroizeAndCheck(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        partialLoad(s, $urandom_range(1, WORDS - 1));
        zeroizeAndCheck(1'b1, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
